// File: rtl/lsu_align_unit.sv
// Load/store alignment unit between the MEM stage and data_memory: sign/zero-extends loads
// and splits misaligned half/word accesses into byte accesses. Define LSU_MISALIGN_TRAP_EN to reject misaligned requests instead.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 3
`endif
`ifndef MASK_B
`define MASK_B 3'b001
`endif
`ifndef MASK_H
`define MASK_H 3'b011
`endif
`ifndef MASK_W
`define MASK_W 3'b111
`endif

module lsu_align_unit #(
    parameter int ADDR_W = `MEM_ADDR_WIDTH,
    parameter int DATA_W = `REG_DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err,
    output logic                   mem_rd_en,
    output logic                   mem_wr_en,
    output logic [`MASK_WIDTH-1:0] mem_mask,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wr_data,
    input  logic [DATA_W-1:0]      mem_rd_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic              err_q, err_d;
    logic              split_q, split_d;

    logic              req_legal;
    logic              req_misaligned;
    logic [1:0]        cnt_last;
    logic [`MASK_WIDTH-1:0] size_mask;

    assign req_ready = rst && (state_q == S_IDLE);

    always_comb begin
        if (req_we) begin
            req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
        end else begin
            req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                         ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        cnt_last = (funct3_q[1:0] == 2'b10) ? 2'd3 : 2'd1;
        case (funct3_q[1:0])
            2'b00:   size_mask = `MASK_B;
            2'b01:   size_mask = `MASK_H;
            default: size_mask = `MASK_W;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        err_d       = err_q;
        split_d     = split_q;
        resp_valid  = 1'b0;
        resp_err    = 1'b0;
        resp_rdata  = '0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_mask    = '0;
        mem_addr    = '0;
        mem_wr_data = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    cnt_d    = 2'd0;
                    asm_d    = '0;
                    split_d  = req_misaligned;
                    if (!req_legal) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
`ifdef LSU_MISALIGN_TRAP_EN
                    end else if (req_misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
`endif
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                mem_rd_en = ~we_q;
                mem_wr_en = we_q;
                if (!split_q) begin
                    mem_mask    = size_mask;
                    mem_addr    = addr_q;
                    mem_wr_data = wdata_q;
                    if (!we_q) begin
                        asm_d = mem_rd_data;
                    end
                    state_d = S_RESP;
                end else begin
                    // Little-endian byte k of the access lives at addr+k, wrapping at the top
                    mem_mask    = `MASK_B;
                    mem_addr    = addr_q + ADDR_W'(cnt_q);
                    mem_wr_data = {{(DATA_W-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
                    if (!we_q) begin
                        asm_d[{cnt_q, 3'b000} +: 8] = mem_rd_data[7:0];
                    end
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == cnt_last) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                if (!we_q && !err_q) begin
                    case (funct3_q)
                        3'b000:  resp_rdata = {{(DATA_W-8){asm_q[7]}}, asm_q[7:0]};
                        3'b001:  resp_rdata = {{(DATA_W-16){asm_q[15]}}, asm_q[15:0]};
                        3'b100:  resp_rdata = {{(DATA_W-8){1'b0}}, asm_q[7:0]};
                        3'b101:  resp_rdata = {{(DATA_W-16){1'b0}}, asm_q[15:0]};
                        default: resp_rdata = asm_q;
                    endcase
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset aborts at once: nothing reaches memory or the consumer while rst is low
        if (!rst) begin
            resp_valid  = 1'b0;
            resp_err    = 1'b0;
            resp_rdata  = '0;
            mem_rd_en   = 1'b0;
            mem_wr_en   = 1'b0;
            mem_mask    = '0;
            mem_addr    = '0;
            mem_wr_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= 2'd0;
            asm_q    <= '0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            asm_q    <= asm_d;
            err_q    <= err_d;
            split_q  <= split_d;
        end
    end

endmodule

// File: tb/tb_lsu_align_unit.sv
// Self-checking bench for lsu_align_unit with a byte-addressed data_memory model and a response scoreboard.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 3
`endif
`ifndef MASK_B
`define MASK_B 3'b001
`endif
`ifndef MASK_H
`define MASK_H 3'b011
`endif
`ifndef MASK_W
`define MASK_W 3'b111
`endif

module tb_lsu_align_unit;

    localparam int AW = `MEM_ADDR_WIDTH;
    localparam int MW = `MASK_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [MW-1:0] mem_mask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wr_data;
    logic [31:0]   mem_rd_data;

    lsu_align_unit #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_mask   (mem_mask),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // data_memory model: byte array, lanes taken from the low bytes of wr_data, zero-extended reads
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          preloadReq;
    logic [AW-1:0] addr1, addr2, addr3;
    assign addr1 = mem_addr + AW'(1);
    assign addr2 = mem_addr + AW'(2);
    assign addr3 = mem_addr + AW'(3);

    always @(posedge clk) begin
        if (preloadReq) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'h00;
            mem[4] <= 8'h01;
            mem[5] <= 8'h7F;
            mem[6] <= 8'hFF;
            mem[7] <= 8'h80;
            mem[(1 << AW) - 1] <= 8'h9A;
            mem[0] <= 8'hBC;
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data[7:0];
            if (mem_mask != `MASK_B) mem[addr1] <= mem_wr_data[15:8];
            if (mem_mask == `MASK_W) begin
                mem[addr2] <= mem_wr_data[23:16];
                mem[addr3] <= mem_wr_data[31:24];
            end
        end
    end

    always_comb begin
        mem_rd_data = 32'h0;
        if (mem_rd_en) begin
            case (mem_mask)
                `MASK_B: mem_rd_data = {24'h0, mem[mem_addr]};
                `MASK_H: mem_rd_data = {16'h0, mem[addr1], mem[mem_addr]};
                `MASK_W: mem_rd_data = {mem[addr3], mem[addr2], mem[addr1], mem[mem_addr]};
                default: mem_rd_data = 32'h0;
            endcase
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } expT;

    typedef struct packed {
        logic          we;
        logic [MW-1:0] mask;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } accT;

    expT sbQ[$];
    accT traceQ[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  acceptCycle = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkTrace(input string tag, input int idx, input logic we, input logic [MW-1:0] mask,
                              input logic [AW-1:0] addr, input logic checkData, input logic [31:0] data);
        if (idx < traceQ.size()) begin
            checkOutput({tag, "_we"}, traceQ[idx].we, we);
            checkOutput({tag, "_mask"}, traceQ[idx].mask, mask);
            checkOutput({tag, "_addr"}, traceQ[idx].addr, addr);
            if (checkData) checkOutput({tag, "_data"}, traceQ[idx].data, data);
        end else begin
            checkOutput({tag, "_present"}, traceQ.size(), idx + 1);
        end
    endtask

    function automatic accT sampleAccess();
        accT a;
        a.we   = mem_wr_en;
        a.mask = mem_mask;
        a.addr = mem_addr;
        a.data = mem_wr_data;
        return a;
    endfunction

    task automatic driveReq(input logic we, input logic [2:0] f3, input logic [AW-1:0] addr, input logic [31:0] wdata);
        int guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("ready_wait", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        acceptCycle = cycleCnt - 1;
    endtask

    task automatic applyStimulus(input string tag, input logic we, input logic [2:0] f3, input logic [AW-1:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata, input logic expErr, input int expLat);
        expT e;
        expT got;
        logic seen = 1'b0;
        e.rdata = expRdata;
        e.err   = expErr;
        e.lat   = expLat;
        traceQ.delete();
        driveReq(we, f3, addr, wdata);
        sbQ.push_back(e);
        for (int c = 0; c < 12 && !seen; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                seen = 1'b1;
                if (sbQ.size() > 0) begin
                    got = sbQ.pop_front();
                    checkOutput({tag, "_rdata"}, resp_rdata, got.rdata);
                    checkOutput({tag, "_err"}, resp_err, got.err);
                    checkOutput({tag, "_latency"}, cycleCnt - acceptCycle, got.lat);
                end
                checkOutput({tag, "_resp_mem_idle"}, {mem_rd_en, mem_wr_en, mem_mask}, '0);
            end else begin
                if (mem_rd_en || mem_wr_en) traceQ.push_back(sampleAccess());
                checkOutput({tag, "_ready_busy"}, req_ready, 1'b0);
            end
        end
        checkOutput({tag, "_resp_seen"}, seen, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, req_ready, 1'b1);
        checkOutput({tag, "_single_pulse"}, resp_valid, 1'b0);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
        preloadReq = 1'b1;
        repeat (2) @(posedge clk);
        #1 preloadReq = 1'b0;
        @(negedge clk);
        checkOutput("rst_req_ready", req_ready, 1'b0);
        checkOutput("rst_resp", {resp_valid, resp_err}, 2'b00);
        checkOutput("rst_rdata", resp_rdata, 32'h0);
        checkOutput("rst_mem_en", {mem_rd_en, mem_wr_en}, 2'b00);
        checkOutput("rst_mem_mask", mem_mask, '0);
        checkOutput("rst_mem_addr", mem_addr, '0);
        checkOutput("rst_mem_wdata", mem_wr_data, 32'h0);
        rst = 1'b1;

        applyStimulus("lb_7", 1'b0, 3'b000, AW'(7), 32'h0, 32'hFFFFFF80, 1'b0, 2);
        checkOutput("lb_7_trace_n", traceQ.size(), 1);
        checkTrace("lb_7_acc", 0, 1'b0, `MASK_B, AW'(7), 1'b0, 32'h0);
        applyStimulus("lbu_7", 1'b0, 3'b100, AW'(7), 32'h0, 32'h00000080, 1'b0, 2);
        applyStimulus("lh_6", 1'b0, 3'b001, AW'(6), 32'h0, 32'hFFFF80FF, 1'b0, 2);
        checkTrace("lh_6_acc", 0, 1'b0, `MASK_H, AW'(6), 1'b0, 32'h0);
        applyStimulus("lhu_6", 1'b0, 3'b101, AW'(6), 32'h0, 32'h000080FF, 1'b0, 2);
        applyStimulus("lw_4", 1'b0, 3'b010, AW'(4), 32'h0, 32'h80FF7F01, 1'b0, 2);
        checkTrace("lw_4_acc", 0, 1'b0, `MASK_W, AW'(4), 1'b0, 32'h0);

        applyStimulus("sb_10", 1'b1, 3'b000, AW'(16), 32'h12345678, 32'h0, 1'b0, 2);
        checkTrace("sb_10_acc", 0, 1'b1, `MASK_B, AW'(16), 1'b1, 32'h12345678);
        applyStimulus("lbu_10", 1'b0, 3'b100, AW'(16), 32'h0, 32'h00000078, 1'b0, 2);

`ifndef LSU_MISALIGN_TRAP_EN
        applyStimulus("sw_5", 1'b1, 3'b010, AW'(5), 32'hAABBCCDD, 32'h0, 1'b0, 5);
        checkOutput("sw_5_trace_n", traceQ.size(), 4);
        checkTrace("sw_5_b0", 0, 1'b1, `MASK_B, AW'(5), 1'b1, 32'h000000DD);
        checkTrace("sw_5_b1", 1, 1'b1, `MASK_B, AW'(6), 1'b1, 32'h000000CC);
        checkTrace("sw_5_b2", 2, 1'b1, `MASK_B, AW'(7), 1'b1, 32'h000000BB);
        checkTrace("sw_5_b3", 3, 1'b1, `MASK_B, AW'(8), 1'b1, 32'h000000AA);
        applyStimulus("lw_4_after", 1'b0, 3'b010, AW'(4), 32'h0, 32'hBBCCDD01, 1'b0, 2);
        applyStimulus("lw_8_after", 1'b0, 3'b010, AW'(8), 32'h0, 32'h000000AA, 1'b0, 2);
        applyStimulus("lh_top", 1'b0, 3'b001, '1, 32'h0, 32'hFFFFBC9A, 1'b0, 3);
        checkTrace("lh_top_b0", 0, 1'b0, `MASK_B, '1, 1'b0, 32'h0);
        checkTrace("lh_top_b1", 1, 1'b0, `MASK_B, '0, 1'b0, 32'h0);
`else
        applyStimulus("sw_5_trap", 1'b1, 3'b010, AW'(5), 32'hAABBCCDD, 32'h0, 1'b1, 1);
        checkOutput("sw_5_trap_trace_n", traceQ.size(), 0);
        applyStimulus("lw_4_after", 1'b0, 3'b010, AW'(4), 32'h0, 32'h80FF7F01, 1'b0, 2);
        applyStimulus("lw_8_after", 1'b0, 3'b010, AW'(8), 32'h0, 32'h00000000, 1'b0, 2);
        applyStimulus("lh_top_trap", 1'b0, 3'b001, '1, 32'h0, 32'h0, 1'b1, 1);
        checkOutput("lh_top_trap_trace_n", traceQ.size(), 0);
`endif

        applyStimulus("ld_f3_011", 1'b0, 3'b011, AW'(4), 32'h0, 32'h0, 1'b1, 1);
        checkOutput("ld_f3_011_trace_n", traceQ.size(), 0);
        applyStimulus("st_f3_100", 1'b1, 3'b100, AW'(4), 32'hDEADBEEF, 32'h0, 1'b1, 1);
        checkOutput("st_f3_100_trace_n", traceQ.size(), 0);

`ifndef LSU_MISALIGN_TRAP_EN
        traceQ.delete();
        driveReq(1'b1, 3'b010, AW'(33), 32'h11223344);
        repeat (2) begin
            @(negedge clk);
            if (mem_wr_en) traceQ.push_back(sampleAccess());
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_gate_wr", mem_wr_en, 1'b0);
        @(negedge clk);
        checkOutput("rst_mid_ready", req_ready, 1'b0);
        checkOutput("rst_mid_resp", {resp_valid, resp_err}, 2'b00);
        checkOutput("rst_mid_rdata", resp_rdata, 32'h0);
        checkOutput("rst_mid_mem", {mem_rd_en, mem_wr_en, mem_mask}, '0);
        checkOutput("rst_mid_addr", mem_addr, '0);
        checkOutput("rst_mid_wdata", mem_wr_data, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_ready_after", req_ready, 1'b1);
        checkOutput("rst_mid_no_resp", resp_valid, 1'b0);
        checkOutput("rst_mid_trace_n", traceQ.size(), 2);
        checkTrace("rst_mid_b0", 0, 1'b1, `MASK_B, AW'(33), 1'b1, 32'h00000044);
        checkTrace("rst_mid_b1", 1, 1'b1, `MASK_B, AW'(34), 1'b1, 32'h00000033);
        applyStimulus("lw_20_after_rst", 1'b0, 3'b010, AW'(32), 32'h0, 32'h00334400, 1'b0, 2);
`else
        applyStimulus("sw_21_trap", 1'b1, 3'b010, AW'(33), 32'h11223344, 32'h0, 1'b1, 1);
        applyStimulus("lw_20_after_trap", 1'b0, 3'b010, AW'(32), 32'h0, 32'h00000000, 1'b0, 2);
`endif
        applyStimulus("lw_24_after", 1'b0, 3'b010, AW'(36), 32'h0, 32'h00000000, 1'b0, 2);

        checkOutput("sb_empty", sbQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
